// File: rtl/vent_scheduler.sv
// Exhaust-vent controller: validates sensor frames, applies humidity hysteresis with minimum
// on-time, and soft-ramps the PWM duty. Optional temperature boost: define VENT_TEMP_BOOST_EN.
module vent_scheduler #(
   parameter int unsigned RAMP_DIV       = 3906,
   parameter int unsigned MIN_ON_CYC     = 60000000,
   parameter int unsigned TIMEOUT_CYC    = 12000000,
   parameter int unsigned BAD_LIMIT      = 3,
   parameter int unsigned FAULT_DUTY     = 128,
   parameter int unsigned TEMP_BOOST_THR = 350
) (
   input  logic        clk1M,
   input  logic        rst_n,
   input  logic [39:0] hym_frame,
   input  logic        hym_valid,
   input  logic [1:0]  cfg_mode,
   input  logic [15:0] cfg_on_thr,
   input  logic [15:0] cfg_off_thr,
   input  logic [7:0]  cfg_duty_max,
   input  logic [7:0]  cfg_manual,
   output logic [7:0]  vent_duty,
   output logic        vent_on,
   output logic [15:0] hum_x10,
   output logic        sensor_fault,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      ST_OFF     = 2'b00,
      ST_RAMP_UP = 2'b01,
      ST_RUN     = 2'b10,
      ST_RAMP_DN = 2'b11
   } state_t;

   localparam int TW = $clog2(RAMP_DIV + 1);
   localparam int MW = $clog2(MIN_ON_CYC + 1);
   localparam int OW = $clog2(TIMEOUT_CYC + 1);
   localparam int BW = $clog2(BAD_LIMIT + 1);

   localparam logic [TW-1:0] TICK_RELOAD  = TW'(RAMP_DIV - 1);
   localparam logic [MW-1:0] MIN_ON_LOAD  = MW'(MIN_ON_CYC);
   localparam logic [OW-1:0] TIMEOUT_TC   = OW'(TIMEOUT_CYC - 1);
   localparam logic [BW-1:0] BAD_MAX      = BW'(BAD_LIMIT);
   localparam logic [BW-1:0] BAD_LAST     = BW'(BAD_LIMIT - 1);
   localparam logic [7:0]    FAULT_TARGET = 8'(FAULT_DUTY);

   logic [7:0]    frame_sum;
   logic          frame_good;
   logic          good_d;
   logic [BW-1:0] bad_cnt;
   logic [OW-1:0] timeout_cnt;
   logic          demand;
   logic [MW-1:0] min_on_cnt;
   logic [15:0]   eff_off_thr;
   logic          auto_mode;
   logic          boost_active;
   logic [7:0]    target;
   logic [TW-1:0] tick_cnt;
   state_t        state_q, state_next;

   assign frame_sum   = hym_frame[39:32] + hym_frame[31:24] + hym_frame[23:16] + hym_frame[15:8];
   assign frame_good  = (frame_sum == hym_frame[7:0]);
   assign auto_mode   = (cfg_mode[1] == cfg_mode[0]);
   assign eff_off_thr = (cfg_off_thr < cfg_on_thr) ? cfg_off_thr : cfg_on_thr;

   // A good frame outranks the timeout terminal count in the same cycle.
   always_ff @(posedge clk1M or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         hum_x10      <= '0;
         bad_cnt      <= '0;
         timeout_cnt  <= '0;
         sensor_fault <= 1'b0;
         good_d       <= 1'b0;
      end else begin
         good_d <= hym_valid && frame_good;
         if (hym_valid && frame_good) begin
            hum_x10      <= hym_frame[39:24];
            bad_cnt      <= '0;
            timeout_cnt  <= '0;
            sensor_fault <= 1'b0;
         end else begin
            if (hym_valid) begin
               if (bad_cnt >= BAD_LAST) begin
                  bad_cnt      <= BAD_MAX;
                  sensor_fault <= 1'b1;
               end else begin
                  bad_cnt <= bad_cnt + 1'b1;
               end
            end
            if (timeout_cnt == TIMEOUT_TC) sensor_fault <= 1'b1;
            else                           timeout_cnt  <= timeout_cnt + 1'b1;
         end
      end
   end

   // Demand is evaluated one cycle after hum_x10 loads; min-on only arms on an off-to-on edge.
   always_ff @(posedge clk1M or negedge rst_n) begin
      if (!rst_n) begin
         demand     <= 1'b0;
         min_on_cnt <= '0;
      end else begin
         if (min_on_cnt != '0) min_on_cnt <= min_on_cnt - 1'b1;
         if (good_d && auto_mode) begin
            if (hum_x10 >= cfg_on_thr) begin
               demand <= 1'b1;
               if (!demand) min_on_cnt <= MIN_ON_LOAD;
            end else if (hum_x10 < eff_off_thr && min_on_cnt == '0) begin
               demand <= 1'b0;
            end
         end
         if (cfg_mode == 2'b01) min_on_cnt <= '0;
      end
   end

`ifdef VENT_TEMP_BOOST_EN
   localparam logic [15:0] BOOST_ON  = 16'(TEMP_BOOST_THR);
   localparam logic [15:0] BOOST_OFF = 16'(TEMP_BOOST_THR - 10);

   logic        boost;
   logic [15:0] temp_x10;

   assign temp_x10     = hym_frame[23:8];
   assign boost_active = boost;

   always_ff @(posedge clk1M or negedge rst_n) begin
      if (!rst_n) begin
         boost <= 1'b0;
      end else if (hym_valid && frame_good) begin
         if (!temp_x10[15] && temp_x10 >= BOOST_ON)      boost <= 1'b1;
         else if (temp_x10[15] || temp_x10 < BOOST_OFF) boost <= 1'b0;
      end
   end
`else
   logic unused_boost_thr;
   assign unused_boost_thr = (TEMP_BOOST_THR != 0);
   assign boost_active     = 1'b0;
`endif

   always_comb begin
      // NOTE: default first so every path assigns target and no latch is inferred.
      target = '0;
      case (cfg_mode)
         2'b01:   target = '0;
         2'b10:   target = cfg_manual;
         default: begin
            if (boost_active)      target = 8'hFF;
            else if (sensor_fault) target = FAULT_TARGET;
            else if (demand)       target = cfg_duty_max;
         end
      endcase
   end

   // Direction is re-decided on every tick, so a mid-ramp target change reverses cleanly.
   always_ff @(posedge clk1M or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt  <= '0;
         vent_duty <= '0;
      end else if (tick_cnt == '0) begin
         tick_cnt <= TICK_RELOAD;
         if (vent_duty < target)      vent_duty <= vent_duty + 1'b1;
         else if (vent_duty > target) vent_duty <= vent_duty - 1'b1;
      end else begin
         tick_cnt <= tick_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk1M or negedge rst_n) begin
      if (!rst_n) state_q <= ST_OFF;
      else        state_q <= state_next;
   end

   always_comb begin
      state_next = ST_OFF;
      if (vent_duty < target)      state_next = ST_RAMP_UP;
      else if (vent_duty > target) state_next = ST_RAMP_DN;
      else if (target != '0)       state_next = ST_RUN;
   end

   assign state   = state_q;
   assign vent_on = (vent_duty != '0);

endmodule

// File: tb/tb_vent_scheduler.sv
// Scoreboard bench for vent_scheduler: the driver pushes time-stamped expectations from a
// behavioural model, and a negedge monitor pops and compares them and checks ramp invariants.
module tb_vent_scheduler;

   localparam int RAMP_DIV       = 4;
   localparam int MIN_ON_CYC     = 1500;
   localparam int TIMEOUT_CYC    = 3000;
   localparam int BAD_LIMIT      = 3;
   localparam int FAULT_DUTY     = 128;
   localparam int TEMP_BOOST_THR = 350;
   localparam int SETTLE         = 1100;

   logic        clk1M = 1'b0;
   logic        rst_n;
   logic [39:0] hym_frame;
   logic        hym_valid;
   logic [1:0]  cfg_mode;
   logic [15:0] cfg_on_thr;
   logic [15:0] cfg_off_thr;
   logic [7:0]  cfg_duty_max;
   logic [7:0]  cfg_manual;
   logic [7:0]  vent_duty;
   logic        vent_on;
   logic [15:0] hum_x10;
   logic        sensor_fault;
   logic [1:0]  state;

   vent_scheduler #(
      .RAMP_DIV(RAMP_DIV), .MIN_ON_CYC(MIN_ON_CYC), .TIMEOUT_CYC(TIMEOUT_CYC),
      .BAD_LIMIT(BAD_LIMIT), .FAULT_DUTY(FAULT_DUTY), .TEMP_BOOST_THR(TEMP_BOOST_THR)
   ) dut (
      .clk1M(clk1M), .rst_n(rst_n), .hym_frame(hym_frame), .hym_valid(hym_valid),
      .cfg_mode(cfg_mode), .cfg_on_thr(cfg_on_thr), .cfg_off_thr(cfg_off_thr),
      .cfg_duty_max(cfg_duty_max), .cfg_manual(cfg_manual), .vent_duty(vent_duty),
      .vent_on(vent_on), .hum_x10(hum_x10), .sensor_fault(sensor_fault), .state(state)
   );

   always #5 clk1M = ~clk1M;

   int cyc = 0;
   always @(posedge clk1M) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   typedef struct {
      int    due;
      string name;
      int    sel;
      int    exp;
   } exp_t;

   exp_t sb_q[$];

   task automatic expect_at(input int due, input string name, input int sel, input int exp);
      exp_t e;
      e.due = due; e.name = name; e.sel = sel; e.exp = exp;
      sb_q.push_back(e);
   endtask

   function automatic logic [31:0] dut_value(input int sel);
      case (sel)
         0:       return {24'd0, vent_duty};
         1:       return {30'd0, state};
         2:       return {16'd0, hum_x10};
         3:       return {31'd0, sensor_fault};
         default: return {31'd0, vent_on};
      endcase
   endfunction

   // Monitor: due expectations, plus per-change ramp invariants.
   bit       mon_en = 1'b0;
   logic [7:0] prev_duty = '0;
   int       last_change = -1;

   always @(negedge clk1M) begin
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
         if (sb_q[i].due <= cyc) begin
            check(sb_q[i].name, dut_value(sb_q[i].sel), 32'(sb_q[i].exp));
            sb_q.delete(i);
         end
      end
      if (mon_en && vent_duty !== prev_duty) begin
         check("duty_step", (vent_duty > prev_duty) ? 32'(vent_duty - prev_duty)
                                                    : 32'(prev_duty - vent_duty), 1);
         check("vent_on_tracks_duty", {31'd0, vent_on}, {31'd0, vent_duty != 8'd0});
         if (last_change >= 0) check("tick_spacing", 32'((cyc - last_change) % RAMP_DIV), 0);
         last_change = cyc;
      end
      prev_duty = vent_duty;
   end

   // Behavioural model: event times in absolute cycles rather than counters.
   int m_hum        = 0;
   int m_bad        = 0;
   int m_last_clear = 0;
   int m_on_edge    = -1000000;
   bit m_dem        = 1'b0;
   bit m_boost      = 1'b0;

   function automatic bit m_auto();
      return (cfg_mode == 2'b00) || (cfg_mode == 2'b11);
   endfunction

   function automatic bit m_fault(input int x);
      return (m_bad >= BAD_LIMIT) || (x >= m_last_clear + TIMEOUT_CYC);
   endfunction

   function automatic int m_target(input int x);
      if (cfg_mode == 2'b01) return 0;
      if (cfg_mode == 2'b10) return int'(cfg_manual);
      if (m_boost)           return 255;
      if (m_fault(x))        return FAULT_DUTY;
      return m_dem ? int'(cfg_duty_max) : 0;
   endfunction

   task automatic step();
      @(posedge clk1M);
      #1;
   endtask

   task automatic set_mode(input logic [1:0] m);
      cfg_mode = m;
      if (m == 2'b01) m_on_edge = -1000000;
   endtask

   task automatic send_frame(input int rh, input int temp, input bit corrupt);
      logic [39:0] f;
      logic [7:0]  cs;
      int          c, on_t, off_t, eff;
      f[39:24] = 16'(rh);
      f[23:8]  = 16'(temp);
      cs = 8'(f[39:32] + f[31:24] + f[23:16] + f[15:8]);
      if (corrupt) cs = cs ^ 8'($urandom_range(1, 255));
      f[7:0] = cs;
      c = cyc;
      hym_frame = f;
      hym_valid = 1'b1;
      if (!corrupt) begin
         m_hum        = rh;
         m_bad        = 0;
         m_last_clear = c + 1;
`ifdef VENT_TEMP_BOOST_EN
         if (temp >= TEMP_BOOST_THR)        m_boost = 1'b1;
         else if (temp < TEMP_BOOST_THR - 10) m_boost = 1'b0;
`endif
         if (m_auto()) begin
            on_t  = int'(cfg_on_thr);
            off_t = int'(cfg_off_thr);
            eff   = (off_t < on_t) ? off_t : on_t;
            if (rh >= on_t) begin
               if (!m_dem) begin
                  m_dem     = 1'b1;
                  m_on_edge = c + 2;
               end
            end else if (rh < eff && c + 2 >= m_on_edge + MIN_ON_CYC + 1) begin
               m_dem = 1'b0;
            end
         end
      end else if (m_bad < BAD_LIMIT) begin
         m_bad++;
      end
      expect_at(c + 1, "hum_x10_after_frame", 2, m_hum);
      expect_at(c + 1, "fault_after_frame", 3, int'(m_fault(c + 1)));
      step();
      hym_valid = 1'b0;
      hym_frame = {$urandom, 8'($urandom)};
   endtask

   task automatic settle(input int n, input string tag);
      int due, t;
      due = cyc + n;
      t   = m_target(due);
      expect_at(due, {tag, "_duty"}, 0, t);
      expect_at(due, {tag, "_state"}, 1, (t == 0) ? 0 : 2);
      expect_at(due, {tag, "_vent_on"}, 4, (t != 0) ? 1 : 0);
      repeat (n) step();
   endtask

   initial begin
      repeat (95000) @(posedge clk1M);
      $display("FAIL watchdog: cycle budget expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, n, rh;
      bit prev_good, bad;

      rst_n = 1'b0; hym_valid = 1'b0; hym_frame = '0;
      cfg_mode = 2'b00; cfg_on_thr = 16'd600; cfg_off_thr = 16'd550;
      cfg_duty_max = 8'd200; cfg_manual = 8'd0;
      step();
      for (int s = 0; s < 5; s++) expect_at(cyc + 1, "reset_value", s, 0);
      step();
      step();
      rst_n = 1'b1;
      m_last_clear = cyc;
      mon_en = 1'b1;
      step();

      // Turn-on: demand lands two cycles after the frame is sampled.
      send_frame(650, 250, 1'b0);
      expect_at(cyc + 1, "state_before_demand", 1, 0);
      expect_at(cyc + 2, "state_ramp_up", 1, 1);
      settle(SETTLE, "turn_on");

      // Low humidity inside the minimum on-time holds the duty.
      send_frame(500, 250, 1'b0);
      settle(300, "min_on_hold");

      // Same frame after expiry ramps down to OFF.
      while (cyc < m_on_edge + MIN_ON_CYC + 10) step();
      send_frame(500, 250, 1'b0);
      settle(SETTLE, "turn_off");

      // Consecutive bad checksums declare a fault and drive the fault duty.
      repeat (3) begin
         send_frame(520, 250, 1'b1);
         repeat (5) step();
      end
      settle(700, "bad_fault");

      send_frame(400, 250, 1'b0);
      settle(700, "fault_recover");

      // Timeout boundary.
      t0 = m_last_clear;
      while (cyc < t0 + TIMEOUT_CYC - 1) step();
      expect_at(cyc, "fault_before_timeout", 3, int'(m_fault(cyc)));
      expect_at(cyc + 1, "fault_at_timeout", 3, int'(m_fault(cyc + 1)));
      settle(700, "timeout_fault");

      // Good frame on the terminal-count cycle wins.
      send_frame(400, 250, 1'b0);
      t0 = m_last_clear;
      while (cyc < t0 + TIMEOUT_CYC - 1) step();
      send_frame(400, 250, 1'b0);
      expect_at(cyc + 3, "fault_after_tc_frame", 3, int'(m_fault(cyc + 3)));
      settle(700, "tc_frame");

      // Forced off in the middle of a ramp-up.
      send_frame(650, 250, 1'b0);
      n = 0;
      while (vent_duty != 8'd90 && n < 2000) begin
         step();
         n++;
      end
      check("reach_duty_90", {24'd0, vent_duty}, 90);
      set_mode(2'b01);
      expect_at(cyc + 1, "state_forced_off", 1, 3);
      settle(90 * RAMP_DIV + 8, "forced_off");

      cfg_manual = 8'd40;
      set_mode(2'b10);
      settle(300, "manual_40");

`ifdef VENT_TEMP_BOOST_EN
      set_mode(2'b00);
      send_frame(300, 360, 1'b0);
      settle(SETTLE, "boost_on");
      send_frame(300, 345, 1'b0);
      settle(300, "boost_hold");
      send_frame(300, 339, 1'b0);
      settle(SETTLE, "boost_off");
`endif

      // Randomised frames, modes and thresholds; bad frames are never back-to-back.
      prev_good = 1'b1;
      for (int k = 0; k < 30; k++) begin
         set_mode(2'($urandom_range(0, 3)));
         cfg_on_thr   = 16'($urandom_range(300, 800));
         cfg_off_thr  = 16'($urandom_range(200, 900));
         cfg_duty_max = 8'($urandom);
         cfg_manual   = 8'($urandom);
         rh  = $urandom_range(0, 1000);
         bad = prev_good && ($urandom_range(0, 3) == 0);
         send_frame(rh, 250, bad);
         prev_good = !bad;
         settle(SETTLE, "random");
      end

      repeat (5) step();
      foreach (sb_q[i]) begin
         checks++;
         errors++;
         $display("FAIL unchecked_%s due at cycle %0d", sb_q[i].name, sb_q[i].due);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
